// File: rtl/spi_ram_wrapper.sv
// rtl/spi_ram_wrapper.sv - SPI slave command front end with an integrated single-port 8-bit RAM
//
// Purpose: deserialises 10-bit command words from MOSI (opcode[9:8], payload[7:0]),
// executes them against an internal RAM, and serialises read data back on MISO.
//
// Ports:
//   clk   in   system clock, all logic on the rising edge
//   rst   in   synchronous active-high reset
//   MOSI  in   serial command data, MSB first, sampled on rising clk
//   MISO  out  serial read data, registered, 0 when not shifting
//   SS_n  in   active-low slave select; high aborts the current frame
module spi_ram_wrapper #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic MOSI,
    output logic MISO,
    input  logic SS_n
);

    localparam int FRAME_BITS = ADDR_SIZE + 2;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        rx_cnt_q;
    logic [3:0]              tx_cnt_q;
    logic                    tx_active_q;
    logic                    rd_addr_received_q;
    logic [FRAME_BITS-1:0]   rx_data_q;
    logic                    rx_valid_q;

    logic [7:0]              tx_data_q;
    logic                    tx_valid_q;
    logic [ADDR_SIZE-1:0]    wr_addr_q;
    logic [ADDR_SIZE-1:0]    rd_addr_q;
    logic [7:0]              mem_q [MEM_DEPTH];

    // ---------------------------------------------------------------
    // SPI slave FSM, shift-in and shift-out
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            rx_cnt_q           <= '0;
            tx_cnt_q           <= '0;
            tx_active_q        <= 1'b0;
            rd_addr_received_q <= 1'b0;
            rx_data_q          <= '0;
            rx_valid_q         <= 1'b0;
            MISO               <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (SS_n) begin
                // Deselect aborts whatever is in flight; rd_addr_received is kept.
                state_q     <= IDLE;
                rx_cnt_q    <= '0;
                tx_cnt_q    <= '0;
                tx_active_q <= 1'b0;
                MISO        <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        rx_cnt_q <= '0;
                        if (!MOSI)
                            state_q <= WRITE;
                        else if (rd_addr_received_q)
                            state_q <= READ_DATA;
                        else
                            state_q <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        // rx_cnt_q saturates at FRAME_BITS, so the word is taken once per frame.
                        if (rx_cnt_q != CNT_W'(FRAME_BITS)) begin
                            rx_data_q <= {rx_data_q[FRAME_BITS-2:0], MOSI};
                            rx_cnt_q  <= rx_cnt_q + 1'b1;
                            if (rx_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                                rx_valid_q <= 1'b1;
                                if (state_q == READ_ADD)
                                    rd_addr_received_q <= 1'b1;
                            end
                        end
                        if (state_q == READ_DATA) begin
                            if (tx_active_q) begin
                                if (tx_cnt_q == 4'd8) begin
                                    MISO               <= 1'b0;
                                    tx_active_q        <= 1'b0;
                                    rd_addr_received_q <= 1'b0;
                                end else begin
                                    MISO     <= tx_data_q[3'd7 - tx_cnt_q[2:0]];
                                    tx_cnt_q <= tx_cnt_q + 4'd1;
                                end
                            end else if (tx_valid_q) begin
                                MISO        <= tx_data_q[7];
                                tx_cnt_q    <= 4'd1;
                                tx_active_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // RAM command decode; acts on the rx_valid cycle regardless of SS_n
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            if (rx_valid_q) begin
                case (rx_data_q[FRAME_BITS-1:FRAME_BITS-2])
                    2'b00:   wr_addr_q <= rx_data_q[ADDR_SIZE-1:0];
                    2'b10:   rd_addr_q <= rx_data_q[ADDR_SIZE-1:0];
                    2'b11: begin
                        tx_data_q  <= mem_q[rd_addr_q];
                        tx_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage array has no reset so it maps onto RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && rx_valid_q && rx_data_q[FRAME_BITS-1:FRAME_BITS-2] == 2'b01)
            mem_q[wr_addr_q] <= rx_data_q[7:0];
    end

endmodule

// File: tb/tb_spi_ram_wrapper.sv
// tb/tb_spi_ram_wrapper.sv - directed self-checking bench for spi_ram_wrapper
module tb_spi_ram_wrapper;

    logic clk;
    logic rst;
    logic MOSI;
    logic MISO;
    logic SS_n;

    int n_checks;
    int n_fail;
    int rxv_cnt;
    int miso_cnt;
    int rxv_base;
    int miso_base;

    localparam logic [31:0] S_IDLE      = 32'd0;
    localparam logic [31:0] S_WRITE     = 32'd2;
    localparam logic [31:0] S_READ_ADD  = 32'd3;
    localparam logic [31:0] S_READ_DATA = 32'd4;

    spi_ram_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .MOSI (MOSI),
        .MISO (MISO),
        .SS_n (SS_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rxv_cnt = 0;
    always @(posedge clk) if (dut.rx_valid_q === 1'b1) rxv_cnt = rxv_cnt + 1;

    initial miso_cnt = 0;
    always @(negedge clk) if (MISO === 1'b1) miso_cnt = miso_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_frame(input logic cmd);
        @(negedge clk) SS_n = 1'b0;
        @(negedge clk) MOSI = cmd;
    endtask

    task automatic shift_bits(input logic [9:0] word, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            @(negedge clk) MOSI = word[i];
        end
    endtask

    task automatic end_frame();
        @(negedge clk) begin SS_n = 1'b1; MOSI = 1'b0; end
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] w;
        logic [7:0] rd_exp;
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        SS_n = 1'b1;
        MOSI = 1'b0;
        dut.mem_q[10] = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_state", 32'(dut.state_q), S_IDLE);
        check("rst_mem10", 32'(dut.mem_q[10]), 32'h00);
        check("rst_rdrcv", 32'(dut.rd_addr_received_q), 32'd0);
        check("rst_wraddr", 32'(dut.wr_addr_q), 32'd0);
        check("rst_rdaddr", 32'(dut.rd_addr_q), 32'd0);

        // Write address = 10
        rxv_base = rxv_cnt;
        w = 10'b00_00001010;
        begin_frame(1'b0);
        @(negedge clk);
        check("wa_state", 32'(dut.state_q), S_WRITE);
        MOSI = w[9];
        shift_bits(w, 8, 0);
        end_frame();
        check("wa_addr", 32'(dut.wr_addr_q), 32'd10);
        check("wa_mem10", 32'(dut.mem_q[10]), 32'h00);
        check("wa_state_idle", 32'(dut.state_q), S_IDLE);
        check("wa_rxv", 32'(rxv_cnt - rxv_base), 32'd1);

        // Write data 0x0A to address 10
        rxv_base = rxv_cnt;
        w = 10'b01_00001010;
        begin_frame(1'b0);
        shift_bits(w, 9, 0);
        end_frame();
        check("wd_mem10", 32'(dut.mem_q[10]), 32'h0A);
        check("wd_rxv", 32'(rxv_cnt - rxv_base), 32'd1);

        // Read address = 10
        rxv_base  = rxv_cnt;
        miso_base = miso_cnt;
        w = 10'b10_00001010;
        begin_frame(1'b1);
        @(negedge clk);
        check("ra_state", 32'(dut.state_q), S_READ_ADD);
        MOSI = w[9];
        shift_bits(w, 8, 0);
        end_frame();
        check("ra_addr", 32'(dut.rd_addr_q), 32'd10);
        check("ra_rcv", 32'(dut.rd_addr_received_q), 32'd1);
        check("ra_miso_quiet", 32'(miso_cnt - miso_base), 32'd0);
        check("ra_rxv", 32'(rxv_cnt - rxv_base), 32'd1);

        // Read data: MISO 8'h0A starting two cycles after the last MOSI bit
        rd_exp = 8'h0A;
        w = 10'b11_00001010;
        begin_frame(1'b1);
        @(negedge clk);
        check("rd_state", 32'(dut.state_q), S_READ_DATA);
        MOSI = w[9];
        shift_bits(w, 8, 0);
        @(negedge clk);
        check("rd_miso_gap0", 32'(MISO), 32'd0);
        @(negedge clk);
        check("rd_miso_gap1", 32'(MISO), 32'd0);
        for (int b = 7; b >= 0; b--) begin
            @(negedge clk);
            check($sformatf("rd_miso_bit%0d", b), 32'(MISO), 32'(rd_exp[b]));
        end
        @(negedge clk);
        check("rd_miso_after", 32'(MISO), 32'd0);
        check("rd_rcv_clear", 32'(dut.rd_addr_received_q), 32'd0);
        repeat (2) @(negedge clk);
        check("rd_hold_state", 32'(dut.state_q), S_READ_DATA);
        check("rd_miso_idle", 32'(MISO), 32'd0);
        end_frame();

        // Next MOSI=1 command goes to READ_ADD again
        w = 10'b10_00110011;
        begin_frame(1'b1);
        @(negedge clk);
        check("ra2_state", 32'(dut.state_q), S_READ_ADD);
        MOSI = w[9];
        shift_bits(w, 8, 0);
        end_frame();
        check("ra2_addr", 32'(dut.rd_addr_q), 32'h33);
        check("ra2_rcv", 32'(dut.rd_addr_received_q), 32'd1);

        // Abort a write-data frame after 5 bits
        rxv_base = rxv_cnt;
        w = 10'b01_11111111;
        begin_frame(1'b0);
        shift_bits(w, 9, 5);
        @(negedge clk) SS_n = 1'b1;
        @(negedge clk);
        check("ab_state", 32'(dut.state_q), S_IDLE);
        repeat (3) @(negedge clk);
        check("ab_mem10", 32'(dut.mem_q[10]), 32'h0A);
        check("ab_rxv", 32'(rxv_cnt - rxv_base), 32'd0);
        check("ab_rcv_kept", 32'(dut.rd_addr_received_q), 32'd1);

        // Full frame after abort decodes correctly
        rxv_base = rxv_cnt;
        w = 10'b01_01010101;
        begin_frame(1'b0);
        shift_bits(w, 9, 0);
        end_frame();
        check("post_mem10", 32'(dut.mem_q[10]), 32'h55);
        check("post_rxv", 32'(rxv_cnt - rxv_base), 32'd1);
        check("post_wraddr", 32'(dut.wr_addr_q), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
